// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between the ex/mem and mem/wb registers.
// Non-memory ops pass straight through combinationally. Loads and stores run
// as a byte-serial little-endian sequence on the 8-bit RAM bus while
// stall_req_o holds the upstream pipeline. ex/mem is frozen by the stall, so
// op, funct3, address and store data are read directly from the inputs for
// the whole access.
// Build option MEM_MISALIGN_CHECK_EN: misaligned LH/LHU/SH and LW/SW skip the
// bus entirely and raise misalign_o for their DONE cycle.
module mem_stage #(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic [31:0]       wdata_i,
    input  logic [1:0]        mem_op_i,
    input  logic [2:0]        mem_funct3_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [31:0]       mem_sdata_i,
    output logic              bus_req_o,
    input  logic              bus_gnt_i,
    output logic [ADDR_W-1:0] mem_a_o,
    output logic [7:0]        mem_dout_o,
    output logic              mem_wr_o,
    input  logic [7:0]        mem_din_i,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [31:0]       wdata_o,
`ifdef MEM_MISALIGN_CHECK_EN
    output logic              misalign_o,
`endif
    output logic              stall_req_o
);

    typedef enum logic [2:0] {IDLE, REQ, XFER, LAST, DONE} state_t;

    state_t            state, state_nxt;
    logic [1:0]        cnt;
    logic [31:0]       acc;
    logic [ADDR_W-1:0] a_live;
    logic [ADDR_W-1:0] a_hold;
    logic              is_load, is_store, is_mem;
    logic [1:0]        last_idx;
    logic [1:0]        lane;
    logic [31:0]       ld_res;
    logic              mis_q;

    // Address bits above the RAM width are intentionally ignored.
    logic unused_addr_hi;
    assign unused_addr_hi = ^mem_addr_i[31:ADDR_W];

    assign is_load  = (mem_op_i == 2'b01);
    assign is_store = (mem_op_i == 2'b10);
    assign is_mem   = is_load | is_store;

    // Index of the final byte: 0 for byte ops, 1 for halfwords, 3 otherwise.
    // 100/101 are only byte/half sizes for loads; as store codes they are undefined.
    always_comb begin
        last_idx = 2'd3;
        case (mem_funct3_i)
            3'b000:  last_idx = 2'd0;
            3'b001:  last_idx = 2'd1;
            3'b100:  if (is_load) last_idx = 2'd0;
            3'b101:  if (is_load) last_idx = 2'd1;
            default: last_idx = 2'd3;
        endcase
    end

    // A byte arrives one cycle after its address, so XFER fills lane cnt-1
    // and LAST fills the final lane.
    assign lane = (state == LAST) ? last_idx : (cnt - 2'd1);

    // Sign/zero extension of the assembled load word.
    always_comb begin
        case (mem_funct3_i)
            3'b000:  ld_res = {{24{acc[7]}}, acc[7:0]};
            3'b001:  ld_res = {{16{acc[15]}}, acc[15:0]};
            3'b100:  ld_res = {24'd0, acc[7:0]};
            3'b101:  ld_res = {16'd0, acc[15:0]};
            default: ld_res = acc;
        endcase
    end

`ifdef MEM_MISALIGN_CHECK_EN
    logic mis_now;
    assign mis_now = is_mem &&
                     ((last_idx == 2'd1 && mem_addr_i[0]) ||
                      (mem_funct3_i == 3'b010 && mem_addr_i[1:0] != 2'b00));

    // Remember a rejected access so DONE can flag it and suppress the write-back.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            mis_q <= 1'b0;
        else if (rdy && state == IDLE)
            mis_q <= mis_now;
    end
`else
    assign mis_q = 1'b0;
`endif

    // State register; frozen while rdy is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else if (rdy)
            state <= state_nxt;
    end

    // Next-state: request, byte loop, final load capture, one DONE cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (is_mem) begin
`ifdef MEM_MISALIGN_CHECK_EN
                    state_nxt = mis_now ? DONE : REQ;
`else
                    state_nxt = REQ;
`endif
                end
            end
            REQ:  if (bus_gnt_i) state_nxt = XFER;
            XFER: if (cnt == last_idx) state_nxt = is_load ? LAST : DONE;
            LAST: state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Byte counter, load accumulator and the last address actually presented.
    // While rdy is low the bus keeps showing the previous cycle's address so
    // the RAM re-delivers the byte that was about to be captured.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= 2'd0;
            acc    <= 32'd0;
            a_hold <= '0;
        end else if (rdy) begin
            a_hold <= a_live;
            case (state)
                IDLE: begin
                    cnt <= 2'd0;
                    acc <= 32'd0;
                end
                REQ:  cnt <= 2'd0;
                XFER: begin
                    cnt <= cnt + 2'd1;
                    if (is_load && cnt != 2'd0)
                        acc[{lane, 3'b000} +: 8] <= mem_din_i;
                end
                LAST: acc[{lane, 3'b000} +: 8] <= mem_din_i;
                default: ;
            endcase
        end
    end

    // Output decode: pass-through in IDLE, bus drive during the access,
    // write-back in DONE; everything reads 0 while reset is asserted.
    always_comb begin
        bus_req_o   = 1'b0;
        a_live      = '0;
        mem_dout_o  = 8'd0;
        mem_wr_o    = 1'b0;
        wd_o        = 5'd0;
        wreg_o      = 1'b0;
        wdata_o     = 32'd0;
        stall_req_o = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
        misalign_o  = 1'b0;
`endif
        if (rst) begin
            wd_o = wd_i;
            case (state)
                IDLE: begin
                    if (is_mem) begin
                        stall_req_o = 1'b1;
                    end else begin
                        wreg_o  = wreg_i;
                        wdata_o = wdata_i;
                    end
                end
                REQ: begin
                    bus_req_o   = 1'b1;
                    stall_req_o = 1'b1;
                end
                XFER: begin
                    bus_req_o   = 1'b1;
                    stall_req_o = 1'b1;
                    a_live      = mem_addr_i[ADDR_W-1:0] + ADDR_W'(cnt);
                    if (is_store) begin
                        mem_dout_o = mem_sdata_i[{cnt, 3'b000} +: 8];
                        mem_wr_o   = rdy;
                    end
                end
                LAST: begin
                    bus_req_o   = 1'b1;
                    stall_req_o = 1'b1;
                    a_live      = mem_addr_i[ADDR_W-1:0] + ADDR_W'(last_idx);
                end
                DONE: begin
                    if (is_load && !mis_q) begin
                        wreg_o  = wreg_i;
                        wdata_o = ld_res;
                    end
`ifdef MEM_MISALIGN_CHECK_EN
                    misalign_o = mis_q;
`endif
                end
                default: ;
            endcase
        end
    end

    assign mem_a_o = rdy ? a_live : a_hold;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed plus randomized checks of mem_stage against a
// byte-array RAM model and an arithmetic model of load/store results.
module tb_mem_stage;

    localparam int ADDR_W = 17;
    localparam int RAM_SZ = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              rdy = 1'b0;
    logic [4:0]        wd_i = '0;
    logic              wreg_i = 1'b0;
    logic [31:0]       wdata_i = '0;
    logic [1:0]        mem_op_i = '0;
    logic [2:0]        mem_funct3_i = '0;
    logic [31:0]       mem_addr_i = '0;
    logic [31:0]       mem_sdata_i = '0;
    logic              bus_req_o;
    logic              bus_gnt_i = 1'b0;
    logic [ADDR_W-1:0] mem_a_o;
    logic [7:0]        mem_dout_o;
    logic              mem_wr_o;
    logic [7:0]        mem_din_i = '0;
    logic [4:0]        wd_o;
    logic              wreg_o;
    logic [31:0]       wdata_o;
    logic              stall_req_o;
`ifdef MEM_MISALIGN_CHECK_EN
    logic              misalign_o;
`endif

    int total = 0;
    int bad = 0;

    logic [7:0]  ram [0:RAM_SZ-1];
    logic [24:0] wlog [$];
    logic        pend_wr = 1'b0;
    logic [16:0] pend_a = '0;
    logic [7:0]  pend_d = '0;

    mem_stage #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .mem_op_i(mem_op_i), .mem_funct3_i(mem_funct3_i),
        .mem_addr_i(mem_addr_i), .mem_sdata_i(mem_sdata_i),
        .bus_req_o(bus_req_o), .bus_gnt_i(bus_gnt_i),
        .mem_a_o(mem_a_o), .mem_dout_o(mem_dout_o), .mem_wr_o(mem_wr_o),
        .mem_din_i(mem_din_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
`ifdef MEM_MISALIGN_CHECK_EN
        .misalign_o(misalign_o),
`endif
        .stall_req_o(stall_req_o)
    );

    always #5 clk = ~clk;

    // Sample the bus mid-cycle, well away from either edge.
    always @(negedge clk) begin
        #2;
        pend_wr = mem_wr_o;
        pend_a  = mem_a_o;
        pend_d  = mem_dout_o;
    end

    // RAM: write on the edge closing a write cycle, read data one cycle late.
    initial begin
        for (int i = 0; i < RAM_SZ; i++) ram[i] = 8'($urandom);
        ram[17'h100] = 8'h44;
        ram[17'h101] = 8'h33;
        ram[17'h102] = 8'h22;
        ram[17'h103] = 8'h11;
        ram[17'h020] = 8'h80;
        ram[17'h040] = 8'h34;
        ram[17'h041] = 8'hF2;
        forever begin
            @(posedge clk);
            if (pend_wr) begin
                ram[pend_a] = pend_d;
                wlog.push_back({pend_a, pend_d});
            end
            mem_din_i <= ram[pend_a];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] op, input logic [2:0] f3);
        if (f3 == 3'b000) return 1;
        if (f3 == 3'b001) return 2;
        if (op == 2'b01 && f3 == 3'b100) return 1;
        if (op == 2'b01 && f3 == 3'b101) return 2;
        return 4;
    endfunction

    // Non-memory op: outputs mirror inputs in the same cycle and nothing starts.
    task automatic pass_op(input logic [1:0] op, input string tag);
        logic [4:0]  wd;
        logic        wr;
        logic [31:0] wdat;
        wd   = 5'($urandom);
        wr   = 1'($urandom);
        wdat = $urandom;
        @(negedge clk);
        mem_op_i = op; wd_i = wd; wreg_i = wr; wdata_i = wdat;
        mem_funct3_i = 3'($urandom); mem_addr_i = $urandom;
        bus_gnt_i = 1'b0; rdy = 1'b1;
        #1;
        check({tag, "_wd"}, wd_o, wd);
        check({tag, "_wreg"}, wreg_o, wr);
        check({tag, "_wdata"}, wdata_o, wdat);
        check({tag, "_stall"}, stall_req_o, 0);
        @(negedge clk);
        #1;
        check({tag, "_stall2"}, stall_req_o, 0);
        check({tag, "_req"}, bus_req_o, 0);
    endtask

    // One load/store from arrival to DONE, with a grant delay and an optional
    // rdy-low window after pause_at post-grant cycles.
    task automatic run_op(input logic [1:0] op, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sdata,
                          input int gdly, input int pause_at, input int pause_len,
                          input string tag, output logic [31:0] got);
        int          n, lat, reqc, pl;
        bit          granted, done, saw_req, wr_bad, mis, ld;
        logic [16:0] a, ai;
        logic [31:0] raw, exp;
        logic [4:0]  wd;
        logic [7:0]  nxt_old;
        n   = nbytes(op, f3);
        ld  = (op == 2'b01);
        a   = addr[16:0];
        mis = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
        mis = (n == 2 && addr[0]) || (f3 == 3'b010 && addr[1:0] != 2'b00);
`endif
        raw = 32'd0;
        for (int i = 0; i < n; i++) begin
            ai  = a + 17'(i);
            raw = raw | (32'(ram[ai]) << (8 * i));
        end
        case (f3)
            3'b000:  exp = {{24{raw[7]}}, raw[7:0]};
            3'b001:  exp = {{16{raw[15]}}, raw[15:0]};
            default: exp = raw;
        endcase
        ai      = a + 17'(n);
        nxt_old = ram[ai];
        wd      = 5'($urandom);
        wlog.delete();

        @(negedge clk);
        mem_op_i = op; mem_funct3_i = f3; mem_addr_i = addr; mem_sdata_i = sdata;
        wd_i = wd; wreg_i = 1'b1; wdata_i = $urandom; rdy = 1'b1; bus_gnt_i = 1'b0;
        #1;
        check({tag, "_stall_arrive"}, stall_req_o, 1);

        lat = 0; reqc = 0; pl = pause_len;
        granted = 0; done = 0; saw_req = 0; wr_bad = 0;
        got = 32'd0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            rdy = 1'b1;
            if (granted && lat == pause_at && pl > 0) begin
                rdy = 1'b0;
                pl--;
            end
            bus_gnt_i = bus_req_o && (reqc >= gdly);
            #1;
            if (!stall_req_o) begin
                done = 1;
                got  = wdata_o;
            end else begin
                if (bus_req_o) saw_req = 1;
                if (bus_req_o && !granted && rdy) reqc++;
                if (ld && mem_wr_o) wr_bad = 1;
                if (!rdy && mem_wr_o) wr_bad = 1;
                if (granted && rdy) lat++;
                if (bus_gnt_i && rdy) granted = 1;
            end
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_req_in_done"}, bus_req_o, 0);
        check({tag, "_wr_bad"}, wr_bad, 0);
        if (mis) begin
            check({tag, "_mis_wreg"}, wreg_o, 0);
            check({tag, "_mis_wdata"}, wdata_o, 0);
            check({tag, "_mis_req"}, saw_req, 0);
            check({tag, "_mis_nwr"}, wlog.size(), 0);
`ifdef MEM_MISALIGN_CHECK_EN
            check({tag, "_mis_flag"}, misalign_o, 1);
`endif
        end else if (ld) begin
            check({tag, "_data"}, wdata_o, exp);
            check({tag, "_wreg"}, wreg_o, 1);
            check({tag, "_wd"}, wd_o, wd);
            check({tag, "_lat"}, lat, n + 1);
        end else begin
            check({tag, "_wreg"}, wreg_o, 0);
            check({tag, "_wdata"}, wdata_o, 0);
            check({tag, "_lat"}, lat, n);
            check({tag, "_nwr"}, wlog.size(), n);
            for (int i = 0; i < n && i < wlog.size(); i++) begin
                ai = a + 17'(i);
                check({tag, "_wlog"}, wlog[i], {ai, sdata[8*i +: 8]});
            end
            ai = a + 17'(n);
            check({tag, "_neighbor"}, ram[ai], nxt_old);
        end

        @(negedge clk);
        mem_op_i = 2'b00; rdy = 1'b1; bus_gnt_i = 1'b0;
        #1;
        check({tag, "_idle_stall"}, stall_req_o, 0);
`ifdef MEM_MISALIGN_CHECK_EN
        check({tag, "_idle_mis"}, misalign_o, 0);
`endif
    endtask

    initial begin
        logic [31:0] got;
        logic [7:0]  old2;
        logic [1:0]  op;
        logic [2:0]  f3;
        int          sel;

        // Reset with a load presented and grant high: every output must read 0.
        wd_i = 5'd3; wreg_i = 1'b1; wdata_i = 32'h55;
        mem_op_i = 2'b01; mem_funct3_i = 3'b010; mem_addr_i = 32'h100;
        mem_sdata_i = 32'hDEADBEEF; bus_gnt_i = 1'b1; rdy = 1'b1; rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_wd", wd_o, 0);
        check("rst_wreg", wreg_o, 0);
        check("rst_wdata", wdata_o, 0);
        check("rst_stall", stall_req_o, 0);
        check("rst_req", bus_req_o, 0);
        check("rst_wr", mem_wr_o, 0);
        check("rst_a", mem_a_o, 0);
        check("rst_dout", mem_dout_o, 0);

        // Release into a non-memory op: same-cycle pass-through.
        @(negedge clk);
        rst = 1'b1; mem_op_i = 2'b00; bus_gnt_i = 1'b0;
        #1;
        check("nonmem_wd", wd_o, 3);
        check("nonmem_wreg", wreg_o, 1);
        check("nonmem_wdata", wdata_o, 32'h55);
        check("nonmem_stall", stall_req_o, 0);
        check("nonmem_req", bus_req_o, 0);

        // Directed spec examples.
        run_op(2'b01, 3'b010, 32'h100, 32'h0, 0, 99, 0, "lw", got);
        check("lw_value", got, 32'h11223344);
        run_op(2'b01, 3'b000, 32'h20, 32'h0, 0, 99, 0, "lb", got);
        check("lb_value", got, 32'hFFFFFF80);
        run_op(2'b01, 3'b100, 32'h20, 32'h0, 1, 99, 0, "lbu", got);
        check("lbu_value", got, 32'h00000080);
        run_op(2'b10, 3'b010, 32'h200, 32'hA1B2C3D4, 0, 99, 0, "sw", got);
        check("sw_b0", ram[17'h200], 8'hD4);
        check("sw_b1", ram[17'h201], 8'hC3);
        check("sw_b2", ram[17'h202], 8'hB2);
        check("sw_b3", ram[17'h203], 8'hA1);
        run_op(2'b01, 3'b001, 32'h40, 32'h0, 3, 1, 2, "lh_pause", got);
        check("lh_value", got, 32'hFFFFF234);
        run_op(2'b01, 3'b101, 32'h40, 32'h0, 2, 0, 1, "lhu_pause", got);
        check("lhu_value", got, 32'h0000F234);
        run_op(2'b10, 3'b001, 32'h500, 32'h0000BEEF, 1, 1, 2, "sh_pause", got);
        run_op(2'b01, 3'b010, 32'h0001FFFE, 32'h0, 0, 99, 0, "lw_wrap", got);
        run_op(2'b01, 3'b000, 32'hFFFFFFFF, 32'h0, 0, 99, 0, "lb_top", got);

        // Reset after two bytes of a store: only those bytes land.
        old2 = ram[17'h302];
        wlog.delete();
        @(negedge clk);
        mem_op_i = 2'b10; mem_funct3_i = 3'b010; mem_addr_i = 32'h300;
        mem_sdata_i = 32'h5A6B7C8D; rdy = 1'b1; bus_gnt_i = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        check("mrst_wd", wd_o, 0);
        check("mrst_wreg", wreg_o, 0);
        check("mrst_wdata", wdata_o, 0);
        check("mrst_stall", stall_req_o, 0);
        check("mrst_req", bus_req_o, 0);
        check("mrst_wr", mem_wr_o, 0);
        check("mrst_a", mem_a_o, 0);
        check("mrst_dout", mem_dout_o, 0);
        @(negedge clk);
        mem_op_i = 2'b00; bus_gnt_i = 1'b0;
        #3;
        check("mrst_nwr", wlog.size(), 2);
        check("mrst_b0", ram[17'h300], 8'h8D);
        check("mrst_b1", ram[17'h301], 8'h7C);
        check("mrst_b2", ram[17'h302], old2);
        @(negedge clk);
        rst = 1'b1;
        run_op(2'b01, 3'b010, 32'h100, 32'h0, 0, 99, 0, "post_rst_lw", got);
        check("post_rst_value", got, 32'h11223344);

        // Randomized mix of pass-through, loads and stores.
        for (int k = 0; k < 40; k++) begin
            sel = $urandom_range(0, 4);
            if (sel == 0) begin
                pass_op(($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00, "rnd_pass");
            end else begin
                if (sel <= 2) begin
                    op = 2'b01;
                    case ($urandom_range(0, 5))
                        0:       f3 = 3'b000;
                        1:       f3 = 3'b001;
                        2:       f3 = 3'b010;
                        3:       f3 = 3'b100;
                        4:       f3 = 3'b101;
                        default: f3 = 3'b011;
                    endcase
                end else begin
                    op = 2'b10;
                    f3 = 3'($urandom_range(0, 2));
                end
                run_op(op, f3, $urandom, $urandom, $urandom_range(0, 3),
                       $urandom_range(0, nbytes(op, f3) - 1), $urandom_range(0, 2),
                       (op == 2'b01) ? "rnd_ld" : "rnd_st", got);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
